// File: rtl/avion_pkg.sv
// Shared definitions for the avion memory arbiter.
// Default geometry, lock limit and port identifiers.
package avion_pkg;

    localparam int AVION_ADDRESS_WIDTH = 6;
    localparam int AVION_DATA_WIDTH    = 10;
    localparam int AVION_LOCK_MAX      = 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/avion_rr_arb2.sv
// Two-port round-robin arbiter with bounded lock.
// Grants are combinational; history and lock state are registered.
module avion_rr_arb2
    import avion_pkg::*;
#(
    parameter int LOCK_MAX = AVION_LOCK_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic a_req,
    input  logic a_lock,
    input  logic b_req,
    input  logic b_lock,
    output logic a_gnt,
    output logic b_gnt
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    port_t          last_gnt;
    port_t          lock_port;
    logic           lock_vld;
    logic [CW-1:0]  lock_cnt;

    logic  own_req;
    logic  oth_req;
    logic  expired;
    logic  hold;
    port_t gnt_port;
    logic  gnt_lock;

    always_comb begin
        own_req = (lock_port == PORT_A) ? a_req : b_req;
        oth_req = (lock_port == PORT_A) ? b_req : a_req;
        expired = (lock_cnt >= CW'(LOCK_MAX));
        // Lock holds unless it has run its course and the other side waits.
        hold    = lock_vld && own_req && !(expired && oth_req);
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        if (rst) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end else if (hold) begin
            a_gnt = (lock_port == PORT_A);
            b_gnt = (lock_port == PORT_B);
        end else if (a_req && b_req) begin
            a_gnt = (last_gnt == PORT_B);
            b_gnt = (last_gnt == PORT_A);
        end else begin
            a_gnt = a_req;
            b_gnt = b_req;
        end
        gnt_port = a_gnt ? PORT_A : PORT_B;
        gnt_lock = a_gnt ? a_lock : b_lock;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt  <= PORT_B;
            lock_port <= PORT_A;
            lock_vld  <= 1'b0;
            lock_cnt  <= '0;
        end else if (a_gnt || b_gnt) begin
            last_gnt <= gnt_port;
            if (gnt_lock) begin
                lock_vld  <= 1'b1;
                lock_port <= gnt_port;
                if (lock_vld && lock_port == gnt_port) begin
                    lock_cnt <= expired ? lock_cnt : lock_cnt + CW'(1);
                end else begin
                    lock_cnt <= CW'(1);
                end
            end else begin
                lock_vld <= 1'b0;
                lock_cnt <= '0;
            end
        end else begin
            lock_vld <= 1'b0;
            lock_cnt <= '0;
        end
    end

endmodule

// File: rtl/avion_mem_arbiter.sv
// CPU / debug-loader arbiter in front of a single-port RAM.
// Muxes the granted request onto the RAM and returns read data a cycle later.
module avion_mem_arbiter
    import avion_pkg::*;
#(
    parameter int ADDRESS_WIDTH = AVION_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = AVION_DATA_WIDTH,
    parameter int LOCK_MAX      = AVION_LOCK_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic                     a_lock,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]    a_wdata,
    output logic                     a_gnt,
    output logic                     a_rvalid,
    output logic [DATA_WIDTH-1:0]    a_rdata,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic                     b_lock,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]    b_wdata,
    output logic                     b_gnt,
    output logic                     b_rvalid,
    output logic [DATA_WIDTH-1:0]    b_rdata,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);

    logic a_rd_q;
    logic b_rd_q;

    avion_rr_arb2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .a_req  (a_req),
        .a_lock (a_lock),
        .b_req  (b_req),
        .b_lock (b_lock),
        .a_gnt  (a_gnt),
        .b_gnt  (b_gnt)
    );

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (a_gnt) begin
            ram_we    = a_we;
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
        end else if (b_gnt) begin
            ram_we    = b_we;
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rd_q <= 1'b0;
            b_rd_q <= 1'b0;
        end else begin
            a_rd_q <= a_gnt && !a_we;
            b_rd_q <= b_gnt && !b_we;
        end
    end

    // A read launched just before reset must not surface while rst is high.
    always_comb begin
        a_rvalid = a_rd_q && !rst;
        b_rvalid = b_rd_q && !rst;
        a_rdata  = a_rvalid ? ram_rdata : '0;
        b_rdata  = b_rvalid ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_avion_mem_arbiter.sv
// Directed bench for avion_mem_arbiter with a behavioural RAM.
// Inputs change 1ns after the rising edge; outputs are checked 3ns later.
module tb_avion_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, a_lock;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt, a_rvalid;
    logic [DW-1:0] a_rdata;
    logic          b_req, b_we, b_lock;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt, b_rvalid;
    logic [DW-1:0] b_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          preload;
    logic [DW-1:0] mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avion_mem_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .LOCK_MAX      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_lock    (a_lock),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_lock    (b_lock),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Registered-read, read-before-write RAM.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[50]   <= 10'd5;
            mem[51]   <= 10'd10;
            ram_rdata <= '0;
        end else begin
            ram_rdata <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_wdata;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic do_reset();
        tick();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        preload = 1;
        idle();
        a_req = 1; a_addr = 6'd50;
        tick();
        preload = 0;
        #3;
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_a_rdata", a_rdata, 0);

        // single read from A
        tick();
        rst = 0;
        #3;
        chk("rd_a_gnt", a_gnt, 1);
        chk("rd_b_gnt", b_gnt, 0);
        chk("rd_ram_addr", ram_addr, 50);
        chk("rd_ram_we", ram_we, 0);
        tick();
        idle();
        #3;
        chk("rd_a_rvalid", a_rvalid, 1);
        chk("rd_a_rdata", a_rdata, 5);
        chk("rd_b_rvalid", b_rvalid, 0);
        chk("rd_b_rdata", b_rdata, 0);
        chk("rd_idle_addr", ram_addr, 0);
        tick();
        #3;
        chk("rd_rvalid_once", a_rvalid, 0);

        // tie from reset
        do_reset();
        a_req = 1; a_addr = 6'd50;
        b_req = 1; b_addr = 6'd51;
        #3;
        chk("tie0_a_gnt", a_gnt, 1);
        chk("tie0_b_gnt", b_gnt, 0);
        chk("tie0_addr", ram_addr, 50);
        tick();
        a_req = 0;
        #3;
        chk("tie1_b_gnt", b_gnt, 1);
        chk("tie1_a_gnt", a_gnt, 0);
        chk("tie1_addr", ram_addr, 51);
        chk("tie1_a_rvalid", a_rvalid, 1);
        chk("tie1_a_rdata", a_rdata, 5);
        chk("tie1_b_rvalid", b_rvalid, 0);
        tick();
        b_req = 0;
        #3;
        chk("tie2_b_rvalid", b_rvalid, 1);
        chk("tie2_b_rdata", b_rdata, 10);
        chk("tie2_a_rvalid", a_rvalid, 0);

        // write then read same address
        tick();
        a_req = 1; a_we = 1; a_addr = 6'd52; a_wdata = 10'd15;
        #3;
        chk("wr_a_gnt", a_gnt, 1);
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, 52);
        chk("wr_ram_wdata", ram_wdata, 15);
        tick();
        a_we = 0; a_wdata = '0;
        #3;
        chk("wr_no_rvalid", a_rvalid, 0);
        chk("rd52_gnt", a_gnt, 1);
        chk("rd52_ram_we", ram_we, 0);
        tick();
        idle();
        #3;
        chk("rd52_rvalid", a_rvalid, 1);
        chk("rd52_rdata", a_rdata, 15);

        // A lock against a waiting B
        do_reset();
        a_req = 1; a_lock = 1; a_addr = 6'd1;
        b_req = 1; b_addr = 6'd2;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            #3;
            chk($sformatf("lockA_a_c%0d", c), a_gnt, (c == 8) ? 0 : 1);
            chk($sformatf("lockA_b_c%0d", c), b_gnt, (c == 8) ? 1 : 0);
        end

        // B lock with A idle, then A arrives after saturation
        do_reset();
        b_req = 1; b_lock = 1; b_addr = 6'd3;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) tick();
            #3;
            chk($sformatf("lockB_b_c%0d", c), b_gnt, 1);
            chk($sformatf("lockB_a_c%0d", c), a_gnt, 0);
        end
        tick();
        a_req = 1; a_addr = 6'd4;
        #3;
        chk("lockB_rel_a", a_gnt, 1);
        chk("lockB_rel_b", b_gnt, 0);
        tick();
        a_req = 0;
        #3;
        chk("lockB_back_b", b_gnt, 1);

        // lock owner drops req: released, round-robin resumes
        do_reset();
        a_req = 1; a_lock = 1;
        #3;
        chk("drop0_a", a_gnt, 1);
        tick();
        a_req = 0; b_req = 1;
        #3;
        chk("drop1_b", b_gnt, 1);
        tick();
        a_req = 1;
        #3;
        chk("drop2_a", a_gnt, 1);
        chk("drop2_b", b_gnt, 0);

        // reset during an outstanding read
        do_reset();
        a_req = 1; a_addr = 6'd50;
        #3;
        chk("rrst_a_gnt", a_gnt, 1);
        tick();
        idle();
        rst = 1;
        #3;
        chk("rrst_a_rvalid", a_rvalid, 0);
        chk("rrst_a_rdata", a_rdata, 0);
        chk("rrst_ram_addr", ram_addr, 0);
        tick();
        rst = 0;
        a_req = 1; a_addr = 6'd50;
        b_req = 1; b_addr = 6'd51;
        #3;
        chk("rrst_post_rvalid", a_rvalid, 0);
        chk("rrst_tie_a", a_gnt, 1);
        chk("rrst_tie_b", b_gnt, 0);

        tick();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
